turn_scheduler: RTL and testbench
=================================

Name: turn_scheduler

Overview:
- Parametrised turn-order sequencer for the board-game core. It generalises the fixed 2/3/4-player turn rotation to MAX_PLAYERS seats.
- Adds skipping of eliminated players, reversible direction, a loadable starting seat and round-wrap reporting.
- Sits between the game-control FSM (which issues advance/start requests) and the score/display logic (which consumes current_player).
- Fully synchronous to one clock; the advance request is edge-detected internally, not used as a clock.

Parameters:
- MAX_PLAYERS, 4, number of physical seats supported (2..16).
- PW, 2, width of a player index; must satisfy 2^PW >= MAX_PLAYERS.
- NW, 3, width of the num_players input; must hold MAX_PLAYERS.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- num_players, input, NW, players in the current game.
- active_mask, input, MAX_PLAYERS, bit i=1 means seat i is still in the game.
- start, input, 1, single-cycle pulse: load start_player and enter RUN.
- start_player, input, PW, seat requested as first to move.
- advance, input, 1, level request from the game FSM; each rising edge is one turn advance.
- reverse, input, 1, 0 = ascending seat order, 1 = descending seat order.
- current_player, output, PW, seat whose turn it is.
- turn_valid, output, 1, high in RUN while current_player is eligible.
- turn_changed, output, 1, one-cycle pulse when current_player is updated.
- round_wrap, output, 1, one-cycle pulse when an advance crosses the seat boundary.
- no_player, output, 1, high when no seat is eligible.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, current_player=0, turn_valid=0, turn_changed=0, round_wrap=0, no_player=0.
  - Advance edge-detect register cleared to 0.
- Effective player count N_eff:
  - num_players values 0..1 give N_eff=1; values above MAX_PLAYERS give N_eff=MAX_PLAYERS.
  - Seat i is eligible iff i < N_eff and active_mask[i]=1.
- Advance edge detection: adv_edge = advance & ~advance_q, where advance_q is advance registered. A level held high produces exactly one advance.
- States:
  - IDLE: advance edges are ignored; current_player holds. start moves to RUN.
  - RUN: responds to start, adv_edge and the fixup rule below. There is no exit to IDLE except reset.
- Start:
  - Takes the first eligible seat at or after start_player in the reverse direction (the seat itself is checked first), wrapping modulo N_eff.
  - start_player >= N_eff is treated as 0.
  - Sets turn_changed=1 for one cycle, even if the value does not change. round_wrap=0.
- Advance in RUN:
  - Next seat = first eligible seat strictly after current_player in the reverse direction, wrapping modulo N_eff.
  - The search is combinational over MAX_PLAYERS; the registered result appears on the cycle after the edge (latency 1).
  - round_wrap=1 when the search passes N_eff-1 -> 0 (reverse=0) or 0 -> N_eff-1 (reverse=1).
  - If current_player is the only eligible seat, it stays unchanged, turn_changed=1, round_wrap=1.
- Simultaneous events:
  - start and adv_edge in the same cycle: start wins and the advance is dropped.
  - reverse is sampled in the same cycle as the start or advance it affects.
- Fixup (RUN, no start, no adv_edge): if current_player becomes ineligible (mask bit cleared or N_eff reduced), the next cycle moves to the next eligible seat in the reverse direction, with turn_changed=1 and round_wrap=0.
- No eligible seat:
  - no_player=1 and turn_valid=0; current_player holds; advances are ignored.
  - When a seat becomes eligible again, the fixup rule applies.
- no_player and turn_valid are registered and updated every cycle from the current inputs.

Test Plan:
- Reset then start: rst low, then high; N=3, mask=0111, start_player=1, start pulse -> current_player=1, turn_valid=1, turn_changed pulse.
- Wrap and hold-high: N=3, mask=0111, from seat 0, three advance edges -> 1, 2, 0; round_wrap only on 2->0. advance held high 5 cycles -> exactly one step.
- Skip and reverse:
  - N=4, mask=1011, from seat 1, advance -> 3.
  - Then reverse=1, advance -> 1; advance again -> 0.
  - Next advance -> 3 with round_wrap=1.
- Elimination mid-turn: in RUN at seat 2 with N=4, clear mask bit 2 -> next cycle current_player=3 with turn_changed=1. Clear all mask bits -> no_player=1, turn_valid=0, current_player holds 3.
- Conflict and clamp:
  - start(start_player=2) together with an advance edge at seat 0 -> current_player=2.
  - num_players=7 with MAX_PLAYERS=4 behaves as N=4.
  - num_players=1 pins play to seat 0 with round_wrap on every advance.
- Async reset mid-game: assert rst between clock edges -> all outputs clear immediately, state=IDLE, advance edges ignored until the next start.

Source files
------------

// File: rtl/turn_scheduler.sv
// Turn-order sequencer: rotates current_player over the eligible seats,
// skipping eliminated seats, with reversible direction and round-wrap pulses.
module turn_scheduler #(
    parameter int unsigned MAX_PLAYERS = 4,
    parameter int unsigned PW          = 2,
    parameter int unsigned NW          = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NW-1:0]          num_players,
    input  logic [MAX_PLAYERS-1:0] active_mask,
    input  logic                   start,
    input  logic [PW-1:0]          start_player,
    input  logic                   advance,
    input  logic                   reverse,
    output logic [PW-1:0]          current_player,
    output logic                   turn_valid,
    output logic                   turn_changed,
    output logic                   round_wrap,
    output logic                   no_player
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic          found;
        logic          wrap;
        logic [PW-1:0] seat;
    } search_t;

    state_t               state, state_n;
    logic                 advance_q;
    logic                 adv_edge;
    int unsigned          n_eff;
    int unsigned          sp_origin;
    logic [MAX_PLAYERS-1:0] elig;
    logic                 any_elig;
    search_t              srch_start, srch_next;
    logic [PW-1:0]        cur_n;
    logic                 tc_n, rw_n, tv_n, np_n;

    function automatic logic bit_at(input logic [MAX_PLAYERS-1:0] v, input int unsigned i);
        return |(v & (MAX_PLAYERS'(1) << i));
    endfunction

    // Walks up to MAX_PLAYERS steps from origin; wrap records whether the
    // boundary was crossed before the first eligible seat was reached.
    function automatic search_t find_seat(input int unsigned origin, input logic rev,
                                          input logic incl, input int unsigned n,
                                          input logic [MAX_PLAYERS-1:0] el);
        search_t     r;
        int unsigned s;
        logic        w;
        r = '0;
        s = origin;
        w = 1'b0;
        if (incl && origin < n && bit_at(el, origin)) begin
            r.found = 1'b1;
            r.seat  = PW'(origin);
        end
        for (int unsigned k = 0; k < MAX_PLAYERS; k++) begin
            if (rev) begin
                if (s == 0) begin
                    s = n - 1;
                    w = 1'b1;
                end else if (s >= n) begin
                    s = n - 1;
                end else begin
                    s = s - 1;
                end
            end else begin
                if (s >= n - 1) begin
                    if (s == n - 1) w = 1'b1;
                    s = 0;
                end else begin
                    s = s + 1;
                end
            end
            if (!r.found && bit_at(el, s)) begin
                r.found = 1'b1;
                r.seat  = PW'(s);
                r.wrap  = w;
            end
        end
        return r;
    endfunction

    always_comb begin
        n_eff = 32'(num_players);
        if (n_eff <= 1)
            n_eff = 1;
        else if (n_eff > MAX_PLAYERS)
            n_eff = MAX_PLAYERS;
    end

    assign elig      = active_mask & ~({MAX_PLAYERS{1'b1}} << n_eff);
    assign any_elig  = |elig;
    assign adv_edge  = advance & ~advance_q;
    assign sp_origin = (32'(start_player) < n_eff) ? 32'(start_player) : 0;

    assign srch_start = find_seat(sp_origin, reverse, 1'b1, n_eff, elig);
    assign srch_next  = find_seat(32'(current_player), reverse, 1'b0, n_eff, elig);

    always_comb begin
        state_n = state;
        cur_n   = current_player;
        tc_n    = 1'b0;
        rw_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    tc_n    = 1'b1;
                    if (srch_start.found) cur_n = srch_start.seat;
                end
            end
            RUN: begin
                if (start) begin
                    tc_n = 1'b1;
                    if (srch_start.found) cur_n = srch_start.seat;
                end else if (adv_edge && srch_next.found) begin
                    tc_n  = 1'b1;
                    rw_n  = srch_next.wrap;
                    cur_n = srch_next.seat;
                end else if (srch_next.found && !bit_at(elig, 32'(current_player))) begin
                    tc_n  = 1'b1;
                    cur_n = srch_next.seat;
                end
            end
            default: state_n = IDLE;
        endcase
        tv_n = (state_n == RUN) && bit_at(elig, 32'(cur_n));
        np_n = ~any_elig;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            advance_q      <= 1'b0;
            current_player <= '0;
            turn_valid     <= 1'b0;
            turn_changed   <= 1'b0;
            round_wrap     <= 1'b0;
            no_player      <= 1'b0;
        end else begin
            state          <= state_n;
            advance_q      <= advance;
            current_player <= cur_n;
            turn_valid     <= tv_n;
            turn_changed   <= tc_n;
            round_wrap     <= rw_n;
            no_player      <= np_n;
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Table-driven bench for turn_scheduler: one vector per clock cycle,
// expectations queued at drive time and checked after the following edge.
module tb_turn_scheduler;

    typedef struct {
        logic       st;
        logic [1:0] sp;
        logic       adv;
        logic       rev;
        logic [2:0] np;
        logic [3:0] mask;
        logic [1:0] cur;
        logic       tv;
        logic       tc;
        logic       rw;
        logic       nop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] num_players = '0;
    logic [3:0] active_mask = '0;
    logic       start = 1'b0;
    logic [1:0] start_player = '0;
    logic       advance = 1'b0;
    logic       reverse = 1'b0;
    logic [1:0] current_player;
    logic       turn_valid, turn_changed, round_wrap, no_player;

    int checks = 0;
    int failures = 0;
    vec_t vt[$];
    vec_t exp_q[$];

    turn_scheduler #(.MAX_PLAYERS(4), .PW(2), .NW(3)) dut (
        .clk(clk), .rst(rst), .num_players(num_players), .active_mask(active_mask),
        .start(start), .start_player(start_player), .advance(advance), .reverse(reverse),
        .current_player(current_player), .turn_valid(turn_valid),
        .turn_changed(turn_changed), .round_wrap(round_wrap), .no_player(no_player)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic [1:0] sp, input logic adv,
                                input logic rev, input logic [2:0] np, input logic [3:0] mask,
                                input logic [1:0] cur, input logic tv, input logic tc,
                                input logic rw, input logic nop);
        vec_t v;
        v.st = st; v.sp = sp; v.adv = adv; v.rev = rev; v.np = np; v.mask = mask;
        v.cur = cur; v.tv = tv; v.tc = tc; v.rw = rw; v.nop = nop;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".cur"}, int'(current_player), 0);
        chk({tag, ".tv"}, int'(turn_valid), 0);
        chk({tag, ".tc"}, int'(turn_changed), 0);
        chk({tag, ".rw"}, int'(round_wrap), 0);
        chk({tag, ".nop"}, int'(no_player), 0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        start = v.st; start_player = v.sp; advance = v.adv; reverse = v.rev;
        num_players = v.np; active_mask = v.mask;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".cur"}, int'(current_player), int'(e.cur));
        chk({tag, ".tv"}, int'(turn_valid), int'(e.tv));
        chk({tag, ".tc"}, int'(turn_changed), int'(e.tc));
        chk({tag, ".rw"}, int'(round_wrap), int'(e.rw));
        chk({tag, ".nop"}, int'(no_player), int'(e.nop));
    endtask

    initial begin
        //             st sp  adv rev np  mask      cur tv tc rw nop
        // reset then start, advances ignored in IDLE
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 3, 4'b0111, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 1, 1, 0, 0, 0));
        // wrap 0->1->2->0
        vt.push_back(mk(1, 0, 0, 0, 3, 4'b0111, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 2, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 0, 1, 0, 0, 0));
        // advance held high five cycles: one step only
        vt.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 1, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0111, 1, 1, 0, 0, 0));
        // skip seat 2, then reverse
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b1011, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 4, 4'b1011, 3, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b1011, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 4, 4'b1011, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 4, 4'b1011, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 4, 4'b1011, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 4, 4'b1011, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 4, 4'b1011, 3, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b1011, 3, 1, 0, 0, 0));
        // elimination of the current seat, then of everyone
        vt.push_back(mk(1, 2, 0, 0, 4, 4'b1111, 2, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b1011, 3, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b1011, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b0000, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 1, 0, 4, 4'b0000, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b0000, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b0001, 0, 1, 1, 0, 0));
        // start beats a simultaneous advance edge
        vt.push_back(mk(1, 2, 1, 0, 4, 4'b1111, 2, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 4, 4'b1111, 2, 1, 0, 0, 0));
        // num_players=7 clamps to 4
        vt.push_back(mk(0, 0, 1, 0, 7, 4'b1111, 3, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 7, 4'b1111, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 7, 4'b1111, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 7, 4'b1111, 0, 1, 0, 0, 0));
        // single player: every advance wraps onto seat 0
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b1111, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 1, 4'b1111, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b1111, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 1, 4'b1111, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b1111, 0, 1, 0, 0, 0));
        // start_player out of range, and start on an eliminated seat
        vt.push_back(mk(0, 0, 1, 0, 3, 4'b1111, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b1111, 1, 1, 0, 0, 0));
        vt.push_back(mk(1, 3, 0, 0, 3, 4'b1111, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 3, 4'b0101, 2, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, 4'b0101, 2, 1, 0, 0, 0));

        #2 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            apply(vt[i], $sformatf("v%0d", i));

        // asynchronous reset between edges, then IDLE ignores advances
        apply(mk(1, 1, 0, 0, 3, 4'b1111, 1, 1, 1, 0, 0), "pre_rst");
        #2 rst = 1'b0;
        #1 check_zero("mid_rst");
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        apply(mk(0, 0, 1, 0, 3, 4'b1111, 0, 0, 0, 0, 0), "idle_adv1");
        apply(mk(0, 0, 0, 0, 3, 4'b1111, 0, 0, 0, 0, 0), "idle_adv0");
        apply(mk(0, 0, 1, 0, 3, 4'b1111, 0, 0, 0, 0, 0), "idle_adv2");
        apply(mk(1, 2, 0, 0, 3, 4'b1111, 2, 1, 1, 0, 0), "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
